// File: rtl/accum_ctrl.sv
// Push-button accumulate controller: two synchronized and debounced active-low keys
// drive a wrapping accumulator with a sticky carry flag and a one-cycle add strobe.
module accum_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             accumulate_n,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] led,
    output logic             overflow,
    output logic             accum_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_HELD
    } state_t;

    // Bit 0 is the accumulate key, bit 1 the clear key.
    logic [1:0] raw_n;
    logic [1:0] deb_level;

    assign raw_n = {clear_n, accumulate_n};

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic          sync1_q, sync1_d;
        logic          sync2_q, sync2_d;
        logic          deb_q, deb_d;
        logic [CW-1:0] cnt_q, cnt_d;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                deb_q   <= 1'b1;
                cnt_q   <= '0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                deb_q   <= deb_d;
                cnt_q   <= cnt_d;
            end
        end

        // The counter only runs while the synchronized level disagrees with the accepted one.
        always_comb begin
            sync1_d = raw_n[gi];
            sync2_d = sync1_q;
            deb_d   = deb_q;
            cnt_d   = '0;
            if (sync2_q != deb_q) begin
                if (cnt_q == CNT_MAX) begin
                    deb_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        assign deb_level[gi] = deb_q;
    end

    logic             deb_acc;
    logic             clr_fall;
    logic [WIDTH:0]   sum;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             pulse_q, pulse_d;
    logic             clr_prev_q, clr_prev_d;

    assign deb_acc  = deb_level[0];
    assign clr_fall = clr_prev_q & ~deb_level[1];
    assign sum      = {1'b0, acc_q} + {1'b0, sw};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            pulse_q    <= 1'b0;
            clr_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            pulse_q    <= pulse_d;
            clr_prev_q <= clr_prev_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        pulse_d    = 1'b0;
        clr_prev_d = deb_level[1];
        case (state_q)
            S_IDLE: begin
                if (!deb_acc) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                state_d = S_HELD;
                if (!clr_fall) begin
                    acc_d   = sum[WIDTH-1:0];
                    ovf_d   = ovf_q | sum[WIDTH];
                    pulse_d = 1'b1;
                end
            end
            S_HELD: begin
                if (deb_acc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A newly accepted clear press overrides any add on the same edge.
        if (clr_fall) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    assign led         = acc_q;
    assign overflow    = ovf_q;
    assign accum_pulse = pulse_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// Self-checking bench for accum_ctrl: directed scenarios plus random key activity,
// compared every cycle against a behavioural model of keys, debounce and accumulator.
module tb_accum_ctrl;

    localparam int W  = 8;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         acc_n;
    logic         clr_n;
    logic [W-1:0] sw;
    logic [W-1:0] led;
    logic         overflow;
    logic         accum_pulse;

    accum_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk          (clk),
        .reset_n      (rst_n),
        .accumulate_n (acc_n),
        .clear_n      (clr_n),
        .sw           (sw),
        .led          (led),
        .overflow     (overflow),
        .accum_pulse  (accum_pulse)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [W-1:0] m_acc;
    logic         m_ovf, m_pulse;
    logic         m_armed, m_pending, m_clr_prev;
    logic         m_line1[2], m_line2[2], m_deb[2];
    logic         m_win[2][DC];

    // Literal expectations posted by the stimulus, checked at the next falling edge
    logic         lit_en = 1'b0;
    string        lit_name = "";
    logic [W-1:0] lit_led;
    logic         lit_ovf, lit_pulse;

    int n_pass = 0;
    int n_total = 0;

    task automatic model_reset();
        m_acc = '0; m_ovf = 1'b0; m_pulse = 1'b0;
        m_armed = 1'b1; m_pending = 1'b0; m_clr_prev = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_line1[k] = 1'b1; m_line2[k] = 1'b1; m_deb[k] = 1'b1;
            for (int i = 0; i < DC; i++) m_win[k][i] = 1'b1;
        end
    endtask

    // One rising edge: the add is one cycle behind the accepted press; a key level is
    // accepted once DC consecutive synchronized samples all disagree with the old level.
    task automatic model_step();
        logic       clr_fall, np, na, all_diff;
        logic [W:0] s;
        logic       raw[2];
        if (!rst_n) begin
            model_reset();
            return;
        end
        raw[0] = acc_n;
        raw[1] = clr_n;
        clr_fall = m_clr_prev && !m_deb[1];
        m_pulse = 1'b0;
        if (m_pending && !clr_fall) begin
            s = {1'b0, m_acc} + {1'b0, sw};
            m_acc = s[W-1:0];
            m_ovf = m_ovf | s[W];
            m_pulse = 1'b1;
        end
        if (clr_fall) begin
            m_acc = '0;
            m_ovf = 1'b0;
        end
        np = m_armed && !m_deb[0];
        na = !m_pending && m_deb[0];
        m_pending = np;
        m_armed = na;
        m_clr_prev = m_deb[1];
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DC - 1; i++) m_win[k][i] = m_win[k][i+1];
            m_win[k][DC-1] = m_line2[k];
            all_diff = 1'b1;
            for (int i = 0; i < DC; i++) all_diff = all_diff & (m_win[k][i] != m_deb[k]);
            if (all_diff) m_deb[k] = m_line2[k];
            m_line2[k] = m_line1[k];
            m_line1[k] = raw[k];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        lit_en = 1'b0;
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_lit(input string nm, input logic [W-1:0] l, input logic o, input logic p);
        lit_name = nm; lit_led = l; lit_ovf = o; lit_pulse = p; lit_en = 1'b1;
    endtask

    task automatic press_acc(input logic [W-1:0] v);
        sw = v;
        acc_n = 1'b0;
        ticks(10);
        acc_n = 1'b1;
        ticks(10);
    endtask

    // Compare process: model every cycle, plus any posted literal expectation
    initial begin
        forever begin
            @(negedge clk);
            n_total++;
            if (led === m_acc && overflow === m_ovf && accum_pulse === m_pulse) n_pass++;
            else $display("FAIL model t=%0t led=%h exp %h ovf=%b exp %b pulse=%b exp %b",
                          $time, led, m_acc, overflow, m_ovf, accum_pulse, m_pulse);
            if (lit_en) begin
                n_total++;
                if (led === lit_led && overflow === lit_ovf && accum_pulse === lit_pulse) n_pass++;
                else $display("FAIL %s t=%0t led=%h exp %h ovf=%b exp %b pulse=%b exp %b",
                              lit_name, $time, led, lit_led, overflow, lit_ovf, accum_pulse, lit_pulse);
            end
        end
    end

    initial begin
        rst_n = 1'b0; acc_n = 1'b1; clr_n = 1'b1; sw = '0;
        model_reset();

        // Reset and idle
        ticks(3);
        expect_lit("reset", 8'h00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        ticks(20);
        expect_lit("idle", 8'h00, 1'b0, 1'b0);

        // Single add with exact latency, no re-add while held
        sw = 8'h05;
        acc_n = 1'b0;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (e == 6)  expect_lit("pre_add", 8'h00, 1'b0, 1'b0);
            if (e == 7)  expect_lit("single_add", 8'h05, 1'b0, 1'b1);
            if (e == 8)  expect_lit("pulse_once", 8'h05, 1'b0, 1'b0);
            if (e == 29) expect_lit("held_no_readd", 8'h05, 1'b0, 1'b0);
        end
        acc_n = 1'b1;
        ticks(10);
        press_acc(8'h03);
        expect_lit("second_add", 8'h08, 1'b0, 1'b0);

        // Glitches shorter than the debounce window
        tick();
        acc_n = 1'b0; ticks(3); acc_n = 1'b1; ticks(10);
        expect_lit("glitch_acc", 8'h08, 1'b0, 1'b0);
        tick();
        clr_n = 1'b0; ticks(3); clr_n = 1'b1; ticks(10);
        expect_lit("glitch_clr", 8'h08, 1'b0, 1'b0);

        // Wrap and sticky overflow
        press_acc(8'hF6);
        expect_lit("pre_wrap", 8'hFE, 1'b0, 1'b0);
        press_acc(8'h03);
        expect_lit("wrap", 8'h01, 1'b1, 1'b0);
        press_acc(8'h01);
        expect_lit("ovf_sticky", 8'h02, 1'b1, 1'b0);

        // Clear, then clear colliding with the add cycle
        press_acc(8'h40);
        expect_lit("pre_clear", 8'h42, 1'b1, 1'b0);
        tick();
        clr_n = 1'b0; ticks(10);
        expect_lit("clear", 8'h00, 1'b0, 1'b0);
        ticks(20);
        clr_n = 1'b1; ticks(10);
        press_acc(8'h11);
        sw = 8'h09;
        acc_n = 1'b0;
        tick();
        clr_n = 1'b0;
        for (int e = 1; e < 30; e++) begin
            tick();
            if (e == 6) expect_lit("pre_collide", 8'h11, 1'b0, 1'b0);
            if (e == 7) expect_lit("collide", 8'h00, 1'b0, 1'b0);
            if (e == 8) expect_lit("collide_held", 8'h00, 1'b0, 1'b0);
        end
        acc_n = 1'b1; clr_n = 1'b1;
        ticks(10);
        press_acc(8'h09);
        expect_lit("post_collide", 8'h09, 1'b0, 1'b0);

        // Asynchronous reset while HELD, key kept pressed through release
        press_acc(8'h07);
        expect_lit("pre_reset", 8'h10, 1'b0, 1'b0);
        tick();
        acc_n = 1'b0;
        ticks(12);
        rst_n = 1'b0;
        model_reset();
        expect_lit("async_reset", 8'h00, 1'b0, 1'b0);
        ticks(3);
        sw = 8'h00;
        rst_n = 1'b1;
        ticks(4);
        expect_lit("no_add_after_rst", 8'h00, 1'b0, 1'b0);
        ticks(20);
        acc_n = 1'b1;
        ticks(10);
        press_acc(8'h02);
        expect_lit("post_reset_add", 8'h02, 1'b0, 1'b0);

        // Random key activity against the model
        for (int it = 0; it < 400; it++) begin
            int kind, d;
            kind = $urandom_range(0, 3);
            d = $urandom_range(1, 8);
            sw = W'($urandom);
            case (kind)
                0: begin acc_n = 1'b0; ticks(d); acc_n = 1'b1; end
                1: begin clr_n = 1'b0; ticks(d); clr_n = 1'b1; end
                2: begin acc_n = 1'b0; tick(); clr_n = 1'b0; ticks(d); acc_n = 1'b1; clr_n = 1'b1; end
                default: tick();
            endcase
            ticks($urandom_range(0, 8));
        end

        ticks(2);
        #10;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/accum_ctrl.md
Name: accum_ctrl

Overview:
- Hardware accumulate controller for the switch/LED/key datapath on the MAX10 board.
- Conditions two raw active-low push-buttons (accumulate, clear): 2-flop synchronizer plus a debouncer for each.
- Each clean accumulate press adds the switch value once to a wrapping accumulator shown on the LEDs; a sticky overflow flag records carry-out.
- Instantiated in the top level beside the SoC, fed by KEY/SW, driving LEDR.

Parameters:
- WIDTH, 8, accumulator/switch/LED width in bits.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); must be >= 2.

Ports:
- clk  input  1  system clock (MAX10_CLK1_50 at top).
- reset_n  input  1  reset; asynchronous assert, active-low.
- accumulate_n  input  1  raw accumulate key, asynchronous, 0 = pressed.
- clear_n  input  1  raw clear key, asynchronous, 0 = pressed.
- sw  input  WIDTH  switch value; sampled only in ADD.
- led  output  WIDTH  accumulator value (registered).
- overflow  output  1  sticky carry-out flag (registered).
- accum_pulse  output  1  one-cycle strobe after each add (registered).

Behaviour:
- Reset (async, reset_n=0):
  - led=0, overflow=0, accum_pulse=0.
  - State=IDLE.
  - Synchronizer flops and debounced levels = 1 (released); debounce counters = 0.
- Synchronizer: two flops per key; a raw change before edge k appears at the sync output after edge k+1.
- Debouncer, per key:
  - Counter clears to 0 whenever sync level == debounced level.
  - Otherwise it increments each cycle.
  - When the counter == DEBOUNCE_CYCLES-1 and the levels still differ: debounced <= sync, counter <= 0.
  - A sync-level pulse shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- FSM states: IDLE, ADD, HELD.
  - IDLE: when debounced accumulate == 0, go to ADD; else stay.
  - ADD (exactly one cycle): acc <= acc + sw mod 2^WIDTH; overflow <= overflow | carry-out; accum_pulse <= 1 on the same edge; go to HELD.
  - HELD: stay until debounced accumulate == 1, then go to IDLE. Holding the key never re-adds.
- Latency: raw press stable before edge 0 -> debounced low after edge 1+DEBOUNCE_CYCLES -> ADD after edge 2+DEBOUNCE_CYCLES -> led/accum_pulse update at edge 3+DEBOUNCE_CYCLES.
- accum_pulse is high for exactly one cycle per add, else 0.
- Clear:
  - Acts on the falling edge of debounced clear (1 -> 0): that edge sets led=0 and overflow=0.
  - Holding clear has no further effect.
  - Clear never changes FSM state.
- Simultaneous clear and add on the same edge: clear wins. led=0, overflow=0, no add; accum_pulse is still 0, and the FSM still goes ADD -> HELD.
- Width rules: sum computed in WIDTH+1 bits; MSB is the carry; led keeps the low WIDTH bits.
- Reset mid-operation (any state, mid-debounce): immediate return to reset values. Keys held through reset deassertion must be debounced afresh before acting.
- No combinational path from any input to any output.

Test Plan:
All tests use DEBOUNCE_CYCLES=4.
1. Reset: reset_n=0 -> led=0x00, overflow=0, accum_pulse=0. Release reset with keys high, idle 20 cycles -> outputs unchanged.
2. Single add: sw=0x05, accumulate_n low before edge 0 and held 30 cycles -> led=0x05 at edge 7; accum_pulse high exactly one cycle; no second add while held. Release, then press with sw=0x03 -> led=0x08.
3. Glitch reject: accumulate_n low for 3 cycles, then high -> led unchanged, accum_pulse never asserted. Repeat with clear_n -> led unchanged.
4. Wrap/overflow: starting from led=0xFE, sw=0x03, one press -> led=0x01, overflow=1. Next press with sw=0x01 -> led=0x02, overflow stays 1.
5. Clear: with led=0x42, overflow=1, press clear -> led=0x00, overflow=0. Align debounced clear fall with the ADD cycle (sw=0x09) -> led=0x00, accum_pulse=0, FSM in HELD. Subsequent release/press adds 0x09.
6. Async reset mid-HELD: with led=0x10, assert reset_n mid-cycle -> led=0, no clock edge required. Deassert with key still held -> no add until debounced; release/press with sw=0x02 -> led=0x02.
